// File: rtl/decode_pkg.sv
// Shared opcode/funct constants, ALU and branch encodings, and the
// combinational MIPS-subset decode function used by the decode stage.
package decode_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned RIDX_W  = 5;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned BR_W    = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_W-1:0] ALU_XOR = 3'd2;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'd3;

    localparam logic [BR_W-1:0] BR_NONE = 2'd0;
    localparam logic [BR_W-1:0] BR_EQ   = 2'd1;
    localparam logic [BR_W-1:0] BR_NE   = 2'd2;

    localparam logic [RIDX_W-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [RIDX_W-1:0]  rs;
        logic [RIDX_W-1:0]  rt;
        logic [RIDX_W-1:0]  dst;
        logic [INSTR_W-1:0] imm;
        logic [ADDR_W-1:0]  addr;
        logic [ALU_W-1:0]   aluop;
        logic               reg_we;
        logic               mem_we;
        logic               mem_re;
        logic [BR_W-1:0]    branch;
        logic               jump;
        logic               jal;
        logic               jr;
        logic               illegal;
        logic               use_rs;
        logic               use_rt;
    } decoded_t;

    // Illegal encodings leave every enable and source-use flag clear so they
    // neither stall nor reserve a destination.
    function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        logic [5:0] op;
        logic [5:0] fn;
        d      = '0;
        op     = instr[31:26];
        fn     = instr[5:0];
        d.rs   = instr[25:21];
        d.rt   = instr[20:16];
        d.imm  = {{16{instr[15]}}, instr[15:0]};
        d.addr = instr[25:0];
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: begin
                        d.aluop  = (fn == FN_ADD) ? ALU_ADD :
                                   (fn == FN_SUB) ? ALU_SUB : ALU_SLT;
                        d.reg_we = 1'b1;
                        d.dst    = instr[15:11];
                        d.use_rs = 1'b1;
                        d.use_rt = 1'b1;
                    end
                    FN_JR: begin
                        d.jr     = 1'b1;
                        d.use_rs = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                d.reg_we = 1'b1;
                d.mem_re = 1'b1;
                d.dst    = d.rt;
                d.use_rs = 1'b1;
            end
            OP_SW: begin
                d.mem_we = 1'b1;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            OP_J: d.jump = 1'b1;
            OP_JAL: begin
                d.jump   = 1'b1;
                d.jal    = 1'b1;
                d.reg_we = 1'b1;
                d.dst    = REG_RA;
            end
            OP_BEQ, OP_BNE: begin
                d.aluop  = ALU_SUB;
                d.branch = (op == OP_BEQ) ? BR_EQ : BR_NE;
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            OP_XORI: begin
                d.imm    = {16'h0000, instr[15:0]};
                d.aluop  = ALU_XOR;
                d.reg_we = 1'b1;
                d.dst    = d.rt;
                d.use_rs = 1'b1;
            end
            OP_ADDI: begin
                d.reg_we = 1'b1;
                d.dst    = d.rt;
                d.use_rs = 1'b1;
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of in-flight writes; lookups report busy/saturated and
// all increments/decrements for one register in a cycle are summed.
module reg_scoreboard
    import decode_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [$clog2(NREG)-1:0]  lookup_a,
    output logic                     busy_a_c,
    input  logic [$clog2(NREG)-1:0]  lookup_b,
    output logic                     busy_b_c,
    input  logic [$clog2(NREG)-1:0]  sat_reg,
    output logic                     sat_c,
    input  logic                     inc,
    input  logic [$clog2(NREG)-1:0]  inc_reg,
    input  logic                     dec,
    input  logic [$clog2(NREG)-1:0]  dec_reg,
    input  logic                     fdec,
    input  logic [$clog2(NREG)-1:0]  fdec_reg
);

    localparam int unsigned IDX_W   = $clog2(NREG);
    localparam int unsigned SUM_W   = CNT_W + 1;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt     [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];

    assign busy_a_c = (lookup_a != '0) && (cnt[lookup_a] != '0);
    assign busy_b_c = (lookup_b != '0) && (cnt[lookup_b] != '0);
    assign sat_c    = (cnt[sat_reg] == CNT_W'(CNT_MAX));

    // Net update per register; decrements below zero clamp (stray writebacks).
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            logic [SUM_W-1:0] up_sum;
            logic [1:0]       dn;
            up_sum = SUM_W'(cnt[i]) + SUM_W'(inc && (inc_reg == IDX_W'(i)));
            dn     = 2'(dec  && (dec_reg  == IDX_W'(i)))
                   + 2'(fdec && (fdec_reg == IDX_W'(i)));
            if (i == 0) begin
                cnt_nxt[i] = '0;
            end else if (up_sum >= SUM_W'(dn)) begin
                cnt_nxt[i] = CNT_W'(up_sum - SUM_W'(dn));
            end else begin
                cnt_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NREG; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: one registered output slot with valid/ready on both
// sides, RAW-hazard and saturation stalls from the scoreboard, and flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(NREG)-1:0]  out_rs,
    output logic [$clog2(NREG)-1:0]  out_rt,
    output logic [$clog2(NREG)-1:0]  out_dst,
    output logic [31:0]              out_imm,
    output logic [25:0]              out_addr,
    output logic [2:0]               out_aluop,
    output logic                     out_reg_we,
    output logic                     out_mem_we,
    output logic                     out_mem_re,
    output logic [1:0]               out_branch,
    output logic                     out_jump,
    output logic                     out_jal,
    output logic                     out_jr,
    output logic                     out_illegal,
    input  logic                     wb_valid,
    input  logic [$clog2(NREG)-1:0]  wb_reg,
    input  logic                     flush
);

    localparam int unsigned IDX_W = $clog2(NREG);

    decoded_t         dec_c;
    logic [IDX_W-1:0] rs_c;
    logic [IDX_W-1:0] rt_c;
    logic [IDX_W-1:0] dst_c;
    logic             busy_rs_c;
    logic             busy_rt_c;
    logic             dst_sat_c;
    logic             hazard_c;
    logic             sat_c;
    logic             xfer_c;
    logic             consume_c;
    logic             inc_c;
    logic             fdec_c;

    always_comb begin
        dec_c = decode_instr(in_instr);
        rs_c  = IDX_W'(dec_c.rs);
        rt_c  = IDX_W'(dec_c.rt);
        dst_c = IDX_W'(dec_c.dst);
    end

    assign hazard_c  = (dec_c.use_rs && busy_rs_c) || (dec_c.use_rt && busy_rt_c);
    assign sat_c     = dec_c.reg_we && (dst_c != '0) && dst_sat_c;
    assign in_ready  = (!out_valid || out_ready) && !hazard_c && !flush && !sat_c;
    assign xfer_c    = in_valid && in_ready;
    assign consume_c = out_valid && out_ready;
    assign inc_c     = xfer_c && dec_c.reg_we && (dst_c != '0);
    // A flushed, unconsumed writer will never write back, so release its slot.
    assign fdec_c    = flush && out_valid && out_reg_we && (out_dst != '0) && !out_ready;

    reg_scoreboard #(
        .NREG  (NREG),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .lookup_a (rs_c),
        .busy_a_c (busy_rs_c),
        .lookup_b (rt_c),
        .busy_b_c (busy_rt_c),
        .sat_reg  (dst_c),
        .sat_c    (dst_sat_c),
        .inc      (inc_c),
        .inc_reg  (dst_c),
        .dec      (wb_valid),
        .dec_reg  (wb_reg),
        .fdec     (fdec_c),
        .fdec_reg (out_dst)
    );

    // Output slot; fields only change on a transfer so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_dst     <= '0;
            out_imm     <= '0;
            out_addr    <= '0;
            out_aluop   <= '0;
            out_reg_we  <= 1'b0;
            out_mem_we  <= 1'b0;
            out_mem_re  <= 1'b0;
            out_branch  <= '0;
            out_jump    <= 1'b0;
            out_jal     <= 1'b0;
            out_jr      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (xfer_c) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rs      <= rs_c;
            out_rt      <= rt_c;
            out_dst     <= dst_c;
            out_imm     <= dec_c.imm;
            out_addr    <= dec_c.addr;
            out_aluop   <= dec_c.aluop;
            out_reg_we  <= dec_c.reg_we;
            out_mem_we  <= dec_c.mem_we;
            out_mem_re  <= dec_c.mem_re;
            out_branch  <= dec_c.branch;
            out_jump    <= dec_c.jump;
            out_jal     <= dec_c.jal;
            out_jr      <= dec_c.jr;
            out_illegal <= dec_c.illegal;
        end else if (out_valid && (out_ready || flush)) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a decode table plus hand-written hazard,
// backpressure, jump, flush, saturation, illegal and reset sequences.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned NREG  = 32;
    localparam int unsigned IDX_W = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_instr;
    logic [PC_W-1:0]  in_pc, out_pc;
    logic [IDX_W-1:0] out_rs, out_rt, out_dst, wb_reg;
    logic [31:0]      out_imm;
    logic [25:0]      out_addr;
    logic [2:0]       out_aluop;
    logic             out_reg_we, out_mem_we, out_mem_re;
    logic [1:0]       out_branch;
    logic             out_jump, out_jal, out_jr, out_illegal;
    logic             wb_valid, flush;

    logic             s_in_valid, s_in_ready, s_out_valid;
    logic [31:0]      s_in_instr;
    logic [PC_W-1:0]  s_out_pc;
    logic [IDX_W-1:0] s_out_rs, s_out_rt, s_out_dst, s_wb_reg;
    logic [31:0]      s_out_imm;
    logic [25:0]      s_out_addr;
    logic [2:0]       s_out_aluop;
    logic             s_out_reg_we, s_out_mem_we, s_out_mem_re;
    logic [1:0]       s_out_branch;
    logic             s_out_jump, s_out_jal, s_out_jr, s_out_illegal;
    logic             s_wb_valid;

    decode_stage #(.PC_W(PC_W), .NREG(NREG), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rs(out_rs), .out_rt(out_rt),
        .out_dst(out_dst), .out_imm(out_imm), .out_addr(out_addr),
        .out_aluop(out_aluop), .out_reg_we(out_reg_we), .out_mem_we(out_mem_we),
        .out_mem_re(out_mem_re), .out_branch(out_branch), .out_jump(out_jump),
        .out_jal(out_jal), .out_jr(out_jr), .out_illegal(out_illegal),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush)
    );

    decode_stage #(.PC_W(PC_W), .NREG(NREG), .CNT_W(1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_instr(s_in_instr), .in_pc(32'h0000_2000), .out_valid(s_out_valid),
        .out_ready(1'b1), .out_pc(s_out_pc), .out_rs(s_out_rs), .out_rt(s_out_rt),
        .out_dst(s_out_dst), .out_imm(s_out_imm), .out_addr(s_out_addr),
        .out_aluop(s_out_aluop), .out_reg_we(s_out_reg_we), .out_mem_we(s_out_mem_we),
        .out_mem_re(s_out_mem_re), .out_branch(s_out_branch), .out_jump(s_out_jump),
        .out_jal(s_out_jal), .out_jr(s_out_jr), .out_illegal(s_out_illegal),
        .wb_valid(s_wb_valid), .wb_reg(s_wb_reg), .flush(1'b0)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic [2:0]  aluop;
        logic        we, mwe, mre;
        logic [1:0]  branch;
        logic        jump, jal, jr, ill;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[14];
    logic [63:0] held;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [31:0] i, input logic [4:0] d,
                                input logic [31:0] im, input logic [2:0] a, input logic we,
                                input logic mwe, input logic mre, input logic [1:0] br,
                                input logic j, input logic jl, input logic r, input logic il);
        vec_t v;
        v.name = n; v.instr = i; v.dst = d; v.imm = im; v.aluop = a; v.we = we;
        v.mwe = mwe; v.mre = mre; v.branch = br; v.jump = j; v.jal = jl; v.jr = r; v.ill = il;
        return v;
    endfunction

    function automatic logic [63:0] exp_pack(input vec_t v);
        return 64'({v.dst, v.imm, v.aluop, v.we, v.mwe, v.mre, v.branch,
                    v.jump, v.jal, v.jr, v.ill});
    endfunction

    function automatic logic [63:0] act_pack();
        return 64'({out_dst, out_imm, out_aluop, out_reg_we, out_mem_we, out_mem_re,
                    out_branch, out_jump, out_jal, out_jr, out_illegal});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        #1;
    endtask

    // Bounded wait for in_ready, then take the transfer edge.
    task automatic wait_accept(input string name);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        chk({name, " accept"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1'b1;
        wb_reg   = r;
        tick();
        wb_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
        s_in_valid = 1'b0; s_in_instr = '0; s_wb_valid = 1'b0; s_wb_reg = '0;

        vecs[0]  = mk("addi",   32'h20080005, 5'd8,  32'h00000005, ALU_ADD, 1, 0, 0, BR_NONE, 0, 0, 0, 0);
        vecs[1]  = mk("lw",     32'h8D09FFFC, 5'd9,  32'hFFFFFFFC, ALU_ADD, 1, 0, 1, BR_NONE, 0, 0, 0, 0);
        vecs[2]  = mk("xori",   32'h3884FFFF, 5'd4,  32'h0000FFFF, ALU_XOR, 1, 0, 0, BR_NONE, 0, 0, 0, 0);
        vecs[3]  = mk("sw",     32'hACC50008, 5'd0,  32'h00000008, ALU_ADD, 0, 1, 0, BR_NONE, 0, 0, 0, 0);
        vecs[4]  = mk("beq",    32'h1022FFFF, 5'd0,  32'hFFFFFFFF, ALU_SUB, 0, 0, 0, BR_EQ,   0, 0, 0, 0);
        vecs[5]  = mk("bne",    32'h14640010, 5'd0,  32'h00000010, ALU_SUB, 0, 0, 0, BR_NE,   0, 0, 0, 0);
        vecs[6]  = mk("j",      32'h08000020, 5'd0,  32'h00000020, ALU_ADD, 0, 0, 0, BR_NONE, 1, 0, 0, 0);
        vecs[7]  = mk("jal",    32'h0C000010, 5'd31, 32'h00000010, ALU_ADD, 1, 0, 0, BR_NONE, 1, 1, 0, 0);
        vecs[8]  = mk("add",    32'h00225020, 5'd10, 32'h00005020, ALU_ADD, 1, 0, 0, BR_NONE, 0, 0, 0, 0);
        vecs[9]  = mk("sub",    32'h00225822, 5'd11, 32'h00005822, ALU_SUB, 1, 0, 0, BR_NONE, 0, 0, 0, 0);
        vecs[10] = mk("slt",    32'h0022602A, 5'd12, 32'h0000602A, ALU_SLT, 1, 0, 0, BR_NONE, 0, 0, 0, 0);
        vecs[11] = mk("jr",     32'h03E00008, 5'd0,  32'h00000008, ALU_ADD, 0, 0, 0, BR_NONE, 0, 0, 1, 0);
        vecs[12] = mk("ill_op", 32'hFC000000, 5'd0,  32'h00000000, ALU_ADD, 0, 0, 0, BR_NONE, 0, 0, 0, 1);
        vecs[13] = mk("ill_fn", 32'h0000003F, 5'd0,  32'h0000003F, ALU_ADD, 0, 0, 0, BR_NONE, 0, 0, 0, 1);

        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset valid", 64'(out_valid), 64'd0);
        chk("reset bundle", act_pack(), 64'd0);
        chk("reset pc", 64'(out_pc), 64'd0);

        // Decode table, each instruction isolated and retired afterwards.
        for (int i = 0; i < 14; i++) begin
            present(vecs[i].instr, 32'h1000 + 32'(4 * i));
            wait_accept(vecs[i].name);
            chk({vecs[i].name, " valid"}, 64'(out_valid), 64'd1);
            chk({vecs[i].name, " bundle"}, act_pack(), exp_pack(vecs[i]));
            chk({vecs[i].name, " pc"}, 64'(out_pc), 64'(32'h1000 + 32'(4 * i)));
            if (vecs[i].we && vecs[i].dst != 5'd0) wb(vecs[i].dst);
            else tick();
        end

        // RAW hazard: lw depends on addi's $8.
        present(32'h20080005, 32'h100);
        wait_accept("h_addi");
        present(32'h8D09FFFC, 32'h104);
        chk("h_addi bundle", act_pack(), exp_pack(vecs[0]));
        chk("h stall0", 64'(in_ready), 64'd0);
        tick();
        chk("h stall1", 64'(in_ready), 64'd0);
        wb_valid = 1'b1; wb_reg = 5'd8; #1;
        chk("h stall wb", 64'(in_ready), 64'd0);
        tick();
        wb_valid = 1'b0; #1;
        chk("h release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; #1;
        chk("h lw bundle", act_pack(), exp_pack(vecs[1]));
        wb(5'd9);

        // Backpressure: xori held three cycles, add waits behind it.
        out_ready = 1'b0;
        present(32'h3884FFFF, 32'h200);
        wait_accept("bp_xori");
        present(32'h00225020, 32'h204);
        held = act_pack();
        chk("bp first", held, exp_pack(vecs[2]));
        for (int c = 0; c < 3; c++) begin
            chk("bp valid", 64'(out_valid), 64'd1);
            chk("bp stable", act_pack(), exp_pack(vecs[2]));
            chk("bp pc", 64'(out_pc), 64'h200);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("bp resume", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; #1;
        chk("bp add", act_pack(), exp_pack(vecs[8]));
        wb(5'd4);
        wb(5'd10);

        // Jumps with cnt[8] busy: jal and j never stall, jr waits on $31.
        present(32'h20080005, 32'h300);
        wait_accept("j_addi");
        present(32'h0C000010, 32'h304);
        chk("jal no stall", 64'(in_ready), 64'd1);
        tick();
        present(32'h08000020, 32'h308);
        chk("jal bundle", act_pack(), exp_pack(vecs[7]));
        wait_accept("j");
        chk("j bundle", act_pack(), exp_pack(vecs[6]));
        present(32'h03E00008, 32'h30C);
        chk("jr stall0", 64'(in_ready), 64'd0);
        tick();
        chk("jr stall1", 64'(in_ready), 64'd0);
        wb(5'd31);
        chk("jr release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; #1;
        chk("jr bundle", act_pack(), exp_pack(vecs[11]));
        wb(5'd8);

        // Flush of held lw $8 together with a writeback: cnt[8] 2 -> 0.
        present(32'h20080005, 32'h400);
        wait_accept("f_addi");
        present(32'h8C080000, 32'h404);
        wait_accept("f_lw");
        out_ready = 1'b0;
        tick();
        chk("f held valid", 64'(out_valid), 64'd1);
        chk("f held dst", 64'(out_dst), 64'd8);
        flush = 1'b1; wb_valid = 1'b1; wb_reg = 5'd8;
        present(32'h01004820, 32'h408);
        chk("f blocks input", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; wb_valid = 1'b0; #1;
        chk("f valid", 64'(out_valid), 64'd0);
        chk("f cnt cleared", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; #1;
        chk("f next dst", 64'(out_dst), 64'd9);
        chk("f next valid", 64'(out_valid), 64'd1);
        wb(5'd9);

        // Illegal with a busy source issues without stall and reserves nothing.
        present(32'h20080005, 32'h500);
        wait_accept("i_addi");
        present(32'h0100403F, 32'h504);
        chk("ill no stall", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; #1;
        chk("ill flag", 64'(out_illegal), 64'd1);
        chk("ill enables", 64'({out_reg_we, out_mem_we, out_mem_re}), 64'd0);
        wb(5'd8);
        present(32'h01004820, 32'h508);
        chk("ill no inc", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0; #1;
        wb(5'd9);

        // Saturation with CNT_W=1.
        s_in_valid = 1'b1; s_in_instr = 32'h20080005; #1;
        chk("sat first", 64'(s_in_ready), 64'd1);
        tick();
        s_in_instr = 32'h00004020; #1;
        chk("sat stall0", 64'(s_in_ready), 64'd0);
        tick();
        chk("sat stall1", 64'(s_in_ready), 64'd0);
        s_wb_valid = 1'b1; s_wb_reg = 5'd8;
        tick();
        s_wb_valid = 1'b0; #1;
        chk("sat release", 64'(s_in_ready), 64'd1);
        tick();
        s_in_valid = 1'b0; #1;
        chk("sat dst", 64'(s_out_dst), 64'd8);
        chk("sat valid", 64'(s_out_valid), 64'd1);

        // Reset during backpressure clears the slot and the scoreboard.
        out_ready = 1'b0;
        present(32'h20080005, 32'h600);
        wait_accept("r_addi");
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("r valid", 64'(out_valid), 64'd0);
        chk("r bundle", act_pack(), 64'd0);
        present(32'h01004820, 32'h604);
        chk("r cnt cleared", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
